uart_rx_fifo: RTL and testbench

// Parametrised next-generation UART receiver for the config-bus subsystem. It has a runtime-configurable

---
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with runtime frame format and baud divider.
// Received characters and their error flags are queued in a small FIFO.
module uart_rx_fifo #(
    parameter int WIDTH_CONFIG_ADDR = 4,
    parameter int WIDTH_CONFIG_DATA = 16,
    parameter int OVERSAMPLE        = 16,
    parameter int DIV_RST           = 26,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
    input  logic                         c_valid,
    output logic                         c_ready,
    output logic [7:0]                   out,
    output logic [2:0]                   error,
    output logic                         valid_out,
    input  logic                         ready_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int DW = WIDTH_CONFIG_DATA;
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [WIDTH_CONFIG_ADDR-1:0] FMT_A = WIDTH_CONFIG_ADDR'(4'b0100);
    localparam logic [WIDTH_CONFIG_ADDR-1:0] DIV_A = WIDTH_CONFIG_ADDR'(4'b0101);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

    state_t        state;
    logic          s1, s2, line_hi;
    logic [1:0]    cfg_bits, cfg_par, f_bits, f_par;
    logic          cfg_stop, f_stop, stop_n;
    logic [DW-1:0] div, tcnt;
    logic [SW-1:0] scnt;
    logic [2:0]    bcnt;
    logic [7:0]    data;
    logic          par_err, frm_err;
    logic          tick, samp, par_en, par_exp;

    assign c_ready = (state == IDLE);
    assign tick    = (state != IDLE) && (state != PUSH) && (tcnt == div);
    assign samp    = tick && (scnt == ((state == START) ? HALF_LAST : FULL_LAST));
    assign par_en  = (f_par == 2'b01) || (f_par == 2'b10);
    assign par_exp = (^data) ^ (f_par == 2'b10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_bits <= 2'd3;
            cfg_par  <= 2'd0;
            cfg_stop <= 1'b0;
            div      <= DW'(DIV_RST);
        end else if (c_valid && c_ready) begin
            if (c_addr == FMT_A)
                {cfg_stop, cfg_par, cfg_bits} <= c_data[4:0];
            else if (c_addr == DIV_A)
                div <= c_data;
        end
    end

    // Frame settings are snapshotted at the start edge; line_hi blocks re-triggering on a held break.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            line_hi <= 1'b0;
            tcnt    <= '0;
            scnt    <= '0;
            bcnt    <= '0;
            stop_n  <= 1'b0;
            data    <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            f_bits  <= 2'd3;
            f_par   <= 2'd0;
            f_stop  <= 1'b0;
        end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (tick)
                scnt <= samp ? '0 : scnt + 1'b1;
            case (state)
                IDLE: begin
                    if (s2) begin
                        line_hi <= 1'b1;
                    end else if (line_hi) begin
                        state   <= START;
                        line_hi <= 1'b0;
                        tcnt    <= '0;
                        scnt    <= '0;
                        bcnt    <= '0;
                        data    <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                        f_bits  <= cfg_bits;
                        f_par   <= cfg_par;
                        f_stop  <= cfg_stop;
                    end
                end
                START: begin
                    if (samp)
                        state <= s2 ? IDLE : DATA;
                end
                DATA: begin
                    if (samp) begin
                        data[bcnt] <= s2;
                        if (bcnt == {1'b1, f_bits}) begin
                            state  <= par_en ? PARITY : STOP;
                            stop_n <= f_stop;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (samp) begin
                        par_err <= (s2 != par_exp);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (samp) begin
                        if (!s2)
                            frm_err <= 1'b1;
                        if (stop_n)
                            stop_n <= 1'b0;
                        else
                            state <= PUSH;
                    end
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [AW:0]   count, count_n;
    logic          ovr, push, pop, full, do_push;
    logic [10:0]   wdata, head_n;

    assign push    = (state == PUSH);
    assign pop     = valid_out && ready_out;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_push = push && (!full || pop);
    assign wdata   = {ovr, par_err, frm_err, data};
    assign count_n = count + (AW+1)'(do_push) - (AW+1)'(pop);
    assign rptr_n  = rptr + AW'(pop);
    // When the FIFO drains to nothing this cycle, the incoming entry becomes the head directly.
    assign head_n  = ((count - (AW+1)'(pop)) == '0) ? wdata : mem[rptr_n];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ovr       <= 1'b0;
            valid_out <= 1'b0;
            out       <= '0;
            error     <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr_n;
            count <= count_n;
            if (push && !do_push)
                ovr <= 1'b1;
            else if (do_push)
                ovr <= 1'b0;
            valid_out <= (count_n != '0);
            {error, out} <= (count_n != '0) ? head_n : 11'd0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames queue expected
// entries, a negedge monitor pops and compares on each handshake.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        line = 1'b1;
    logic [3:0]  c_addr = '0;
    logic [15:0] c_data = '0;
    logic        c_valid = 1'b0;
    logic        c_ready;
    logic [7:0]  dout;
    logic [2:0]  err;
    logic        valid_out;
    logic        ready_out = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int start_c = 0;
    logic v_d = 1'b0;
    logic [10:0] exp_q[$];
    logic [10:0] item;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .in(line),
        .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
        .out(dout), .error(err), .valid_out(valid_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && valid_out && !v_d)
            rise_cyc = cyc;
        v_d = valid_out;
        if (rst && valid_out && ready_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_entry: got err=%b out=%h, required no entry", err, dout);
            end else begin
                item = exp_q.pop_front();
                if ({err, dout} !== item) begin
                    errors++;
                    $display("FAIL fifo_entry: got err=%b out=%h, required err=%b out=%h",
                             err, dout, item[10:8], item[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, expv);
        end
    endtask

    task automatic bitx(input logic b, input int per);
        line = b;
        repeat (per) @(posedge clk);
        #1;
    endtask

    // Frame plus one idle bit; parity bit and second stop bit are given explicitly.
    task automatic send(input logic [7:0] d, input int nb, input bit has_par,
                        input logic pbit, input int nstop, input logic stop2, input int per);
        bitx(1'b0, per);
        for (int i = 0; i < nb; i++)
            bitx(d[i], per);
        if (has_par)
            bitx(pbit, per);
        bitx(1'b1, per);
        if (nstop == 2)
            bitx(stop2, per);
        bitx(1'b1, per);
    endtask

    task automatic cfg(input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        while (!c_ready && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        c_addr  = a;
        c_data  = d;
        c_valid = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_valid", valid_out, 0);
        check("rst_out", dout, 0);
        check("rst_error", err, 0);
        check("rst_c_ready", c_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;

        cfg(4'b0101, 16'd0);
        repeat (5) @(posedge clk); #1;
        check("c_ready_idle", c_ready, 1);

        // 8N1 0xA5: start seen after sync, PUSH 155 cycles later, valid one cycle after
        exp_q.push_back({3'b000, 8'hA5});
        rise_cyc = -1;
        start_c = cyc;
        send(8'hA5, 8, 0, 1'b0, 1, 1'b1, 16);
        wait_drain("drain_a5", 200);
        check("valid_latency", rise_cyc - start_c, 156);

        // 7 data bits, odd parity (FMT 0x0A); 0x35 has four ones
        cfg(4'b0100, 16'h000A);
        exp_q.push_back({3'b000, 8'h35});
        send(8'h35, 7, 1, 1'b1, 1, 1'b1, 16);
        exp_q.push_back({3'b010, 8'h35});
        send(8'h35, 7, 1, 1'b0, 1, 1'b1, 16);
        wait_drain("drain_parity", 200);

        // 8N2: second stop low -> framing error; clean frame afterwards
        cfg(4'b0100, 16'h0013);
        exp_q.push_back({3'b001, 8'h5A});
        send(8'h5A, 8, 0, 1'b0, 2, 1'b0, 16);
        exp_q.push_back({3'b000, 8'h3C});
        send(8'h3C, 8, 0, 1'b0, 2, 1'b1, 16);
        wait_drain("drain_8n2", 200);

        // glitch of 4 ticks -> false start
        cfg(4'b0100, 16'h0003);
        line = 1'b0;
        repeat (4) @(posedge clk); #1;
        line = 1'b1;
        repeat (60) @(posedge clk); #1;
        check("glitch_no_entry", valid_out, 0);
        check("glitch_idle", c_ready, 1);

        // break: one framing-error entry with data 0, no repeats while low
        exp_q.push_back({3'b001, 8'h00});
        line = 1'b0;
        repeat (400) @(posedge clk); #1;
        check("break_single", exp_q.size(), 0);
        line = 1'b1;
        repeat (40) @(posedge clk); #1;
        wait_drain("drain_break", 50);

        // overrun: five chars into a 4-deep FIFO with no consumer
        ready_out = 1'b0;
        exp_q.push_back({3'b000, 8'h11});
        exp_q.push_back({3'b000, 8'h22});
        exp_q.push_back({3'b000, 8'h33});
        exp_q.push_back({3'b000, 8'h44});
        send(8'h11, 8, 0, 1'b0, 1, 1'b1, 16);
        send(8'h22, 8, 0, 1'b0, 1, 1'b1, 16);
        send(8'h33, 8, 0, 1'b0, 1, 1'b1, 16);
        send(8'h44, 8, 0, 1'b0, 1, 1'b1, 16);
        send(8'h55, 8, 0, 1'b0, 1, 1'b1, 16);
        check("hold_valid", valid_out, 1);
        check("hold_head", {err, dout}, {3'b000, 8'h11});
        ready_out = 1'b1;
        wait_drain("drain_full", 50);
        exp_q.push_back({3'b100, 8'h66});
        send(8'h66, 8, 0, 1'b0, 1, 1'b1, 16);
        wait_drain("drain_overrun", 200);

        // config request during a frame is held off until IDLE
        exp_q.push_back({3'b000, 8'h96});
        fork
            send(8'h96, 8, 0, 1'b0, 1, 1'b1, 16);
            begin
                int n = 0;
                repeat (40) @(posedge clk); #1;
                c_addr  = 4'b0110;
                c_data  = 16'hFFFF;
                c_valid = 1'b1;
                check("busy_c_ready_a", c_ready, 0);
                repeat (60) @(posedge clk); #1;
                check("busy_c_ready_b", c_ready, 0);
                while (!c_ready && n < 500) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("c_ready_returns", c_ready, 1);
                @(posedge clk); #1;
                c_valid = 1'b0;
            end
        join
        wait_drain("drain_busy", 200);

        // div = 3 -> 64-cycle bit period
        cfg(4'b0101, 16'd3);
        exp_q.push_back({3'b000, 8'h4B});
        send(8'h4B, 8, 0, 1'b0, 1, 1'b1, 64);
        wait_drain("drain_div3", 800);

        // reset with a full FIFO and a frame in flight, 7N1 configured
        cfg(4'b0100, 16'h0002);
        ready_out = 1'b0;
        send(8'h01, 7, 0, 1'b0, 1, 1'b1, 64);
        send(8'h02, 7, 0, 1'b0, 1, 1'b1, 64);
        send(8'h03, 7, 0, 1'b0, 1, 1'b1, 64);
        send(8'h04, 7, 0, 1'b0, 1, 1'b1, 64);
        check("full_head", {err, dout}, {3'b000, 8'h01});
        line = 1'b0;
        repeat (100) @(posedge clk); #1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", valid_out, 0);
        check("arst_out", dout, 0);
        check("arst_error", err, 0);
        check("arst_c_ready", c_ready, 1);
        exp_q.delete();
        line = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        ready_out = 1'b1;
        repeat (5) @(posedge clk); #1;

        // default 8N1 at div 26 -> 432-cycle bits
        exp_q.push_back({3'b000, 8'hC3});
        send(8'hC3, 8, 0, 1'b0, 1, 1'b1, 432);
        wait_drain("drain_after_rst", 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
